add_round_key_seq: RTL and testbench

Sequential, parametrised AddRoundKey engine for the AES datapath. It holds a bank of round keys written by the key schedule. It accepts a state block plus round index over a valid/ready handshake and XORs the state with the selected round key, LANES bytes per cycle. The result is presented on a valid/ready output. It sits between the MixColumns/ShiftRows stage and the next round's SubBytes, and replaces the single-shot combinational AddRoundKey.

---
 rtl/add_round_key_seq.sv | 127 ++++++++++++
 tb/tb_add_round_key_seq.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_round_key_seq.sv
// Multi-cycle AES AddRoundKey: XORs a latched state block with a
// banked round key, LANES bytes per cycle, over valid/ready handshakes.
module add_round_key_seq #(
   parameter int WORD_SIZE  = 8,
   parameter int ARRAY_SIZE = 16,
   parameter int LANES      = 4,
   parameter int NUM_ROUNDS = 11,
   localparam int B  = WORD_SIZE * ARRAY_SIZE,
   localparam int RW = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1,
   localparam int N  = ARRAY_SIZE / LANES,
   localparam int CW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          key_wr_en,
   input  logic [RW-1:0] key_wr_addr,
   input  logic [B-1:0]  key_wr_data,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [B-1:0]  in_state,
   input  logic [RW-1:0] in_round,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [B-1:0]  out_state,
   output logic [RW-1:0] out_round,
   output logic          out_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [B-1:0]  key_bank [NUM_ROUNDS];
   logic [B-1:0]  work_state;
   logic [B-1:0]  work_key;
   logic [B-1:0]  sel_key;
   logic [B-1:0]  xor_nxt;
   logic [RW-1:0] work_round;
   logic          work_err;
   logic          sel_err;
   logic [CW-1:0] pass;
   logic          accept;
   logic          last;

   assign accept = in_valid && in_ready;
   assign last   = (int'(pass) == N - 1);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept)    state_nxt = BUSY;
         BUSY:    if (last)      state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   assign out_state = work_state;
   assign out_round = work_round;
   assign out_err   = work_err;

   // Out-of-range writes match no slot and fall through silently.
   always_ff @(posedge clk) begin
      for (int r = 0; r < NUM_ROUNDS; r++) begin
         if (reset)
            key_bank[r] <= '0;
         else if (key_wr_en && int'(key_wr_addr) == r)
            key_bank[r] <= key_wr_data;
      end
   end

   // Reads the registered bank, so a same-cycle write is not seen.
   always_comb begin
      sel_key = '0;
      sel_err = 1'b1;
      for (int r = 0; r < NUM_ROUNDS; r++) begin
         if (int'(in_round) == r) begin
            sel_key = key_bank[r];
            sel_err = 1'b0;
         end
      end
   end

   always_comb begin
      xor_nxt = work_state;
      for (int i = 0; i < ARRAY_SIZE; i++) begin
         if (i / LANES == int'(pass))
            xor_nxt[i*WORD_SIZE +: WORD_SIZE] =
               work_state[i*WORD_SIZE +: WORD_SIZE] ^
               work_key[i*WORD_SIZE +: WORD_SIZE];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         work_state <= '0;
         work_key   <= '0;
         work_round <= '0;
         work_err   <= 1'b0;
         pass       <= '0;
      end else if (accept) begin
         work_state <= in_state;
         work_key   <= sel_key;
         work_round <= in_round;
         work_err   <= sel_err;
         pass       <= '0;
      end else if (state == BUSY) begin
         work_state <= xor_nxt;
         pass       <= last ? '0 : pass + CW'(1);
      end
   end

endmodule

// File: tb/tb_add_round_key_seq.sv
// Randomised bench for add_round_key_seq against a whole-block XOR
// model; LANES=4 is the main instance, LANES=1/16 check latency.
module tb_add_round_key_seq;

   localparam int B = 128;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          key_wr_en = 1'b0;
   logic [3:0]    key_wr_addr = '0;
   logic [B-1:0]  key_wr_data = '0;
   logic          in_valid = 1'b0;
   logic [B-1:0]  in_state = '0;
   logic [3:0]    in_round = '0;
   logic          out_ready = 1'b0;

   logic          rdy4, vld4, err4;
   logic [B-1:0]  st4;
   logic [3:0]    rnd4;
   logic          rdy1, vld1, err1;
   logic [B-1:0]  st1;
   logic [3:0]    rnd1;
   logic          rdy16, vld16, err16;
   logic [B-1:0]  st16;
   logic [3:0]    rnd16;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   logic [B-1:0] kb [16];

   always #5 clk = ~clk;

   add_round_key_seq #(.LANES(4)) u4 (
      .clk(clk), .reset(reset),
      .key_wr_en(key_wr_en), .key_wr_addr(key_wr_addr),
      .key_wr_data(key_wr_data),
      .in_valid(in_valid), .in_ready(rdy4),
      .in_state(in_state), .in_round(in_round),
      .out_valid(vld4), .out_ready(out_ready),
      .out_state(st4), .out_round(rnd4), .out_err(err4)
   );

   add_round_key_seq #(.LANES(1)) u1 (
      .clk(clk), .reset(reset),
      .key_wr_en(key_wr_en), .key_wr_addr(key_wr_addr),
      .key_wr_data(key_wr_data),
      .in_valid(in_valid), .in_ready(rdy1),
      .in_state(in_state), .in_round(in_round),
      .out_valid(vld1), .out_ready(out_ready),
      .out_state(st1), .out_round(rnd1), .out_err(err1)
   );

   add_round_key_seq #(.LANES(16)) u16 (
      .clk(clk), .reset(reset),
      .key_wr_en(key_wr_en), .key_wr_addr(key_wr_addr),
      .key_wr_data(key_wr_data),
      .in_valid(in_valid), .in_ready(rdy16),
      .in_state(in_state), .in_round(in_round),
      .out_valid(vld16), .out_ready(out_ready),
      .out_state(st16), .out_round(rnd16), .out_err(err16)
   );

   function automatic logic [B-1:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Whole-block reference: state XOR key, or passthrough if unmapped.
   function automatic logic [B-1:0] model(input logic [B-1:0] s,
                                          input int r);
      return (r < 11) ? (s ^ kb[r]) : s;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic write_key(input int a, input logic [B-1:0] d);
      key_wr_en   = 1'b1;
      key_wr_addr = 4'(a);
      key_wr_data = d;
      step();
      key_wr_en = 1'b0;
      if (a < 11) kb[a] = d;
   endtask

   task automatic run_block(input  logic [B-1:0] s,
                            input  logic [3:0]   r,
                            input  bit           wr,
                            input  int           wa,
                            input  logic [B-1:0] wd,
                            output int           lat,
                            output logic [B-1:0] ost,
                            output logic [3:0]   ornd,
                            output logic         oerr);
      in_valid = 1'b1;
      in_state = s;
      in_round = r;
      if (wr) begin
         key_wr_en   = 1'b1;
         key_wr_addr = 4'(wa);
         key_wr_data = wd;
      end
      step();
      in_valid  = 1'b0;
      key_wr_en = 1'b0;
      if (wr && wa < 11) kb[wa] = wd;
      lat = 0;
      while (!vld4 && lat < 40) begin
         step();
         lat++;
      end
      if (!vld4) lat = -1;
      ost  = st4;
      ornd = rnd4;
      oerr = err4;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) step();
      vectors++;
      if (rdy4 !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_in_ready got %b exp 1", rdy4);
      end
      vectors++;
      if (vld4 !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_out_valid got %b exp 0", vld4);
      end
      vectors++;
      if (st4 !== '0) begin
         miscompares++;
         $display("FAIL rst_out_state got %h exp 0", st4);
      end
      vectors++;
      if (rnd4 !== 4'd0 || err4 !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_round_err got %0d/%b exp 0/0", rnd4, err4);
      end
      vectors++;
      if (rdy1 !== 1'b1 || rdy16 !== 1'b1 || vld1 !== 1'b0 ||
          vld16 !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_variants got rdy %b%b vld %b%b exp 11 00",
                  rdy1, rdy16, vld1, vld16);
      end
      reset = 1'b0;
      for (int i = 0; i < 16; i++) kb[i] = '0;
      step();
      vectors++;
      if (rdy4 !== 1'b1 || vld4 !== 1'b0) begin
         miscompares++;
         $display("FAIL post_rst got rdy %b vld %b exp 1 0", rdy4, vld4);
      end
   endtask

   task automatic test_fips();
      logic [B-1:0] exp_st;
      int l4, l1, l16;
      exp_st = 128'h00102030405060708090a0b0c0d0e0f0;
      write_key(0, 128'h000102030405060708090a0b0c0d0e0f);
      in_valid = 1'b1;
      in_state = 128'h00112233445566778899aabbccddeeff;
      in_round = 4'd0;
      step();
      in_valid = 1'b0;
      l4 = -1; l1 = -1; l16 = -1;
      for (int c = 0; c <= 40; c++) begin
         if (vld4  && l4  < 0) l4  = c;
         if (vld1  && l1  < 0) l1  = c;
         if (vld16 && l16 < 0) l16 = c;
         if (l4 >= 0 && l1 >= 0 && l16 >= 0) break;
         step();
      end
      vectors++;
      if (l4 != 4) begin
         miscompares++;
         $display("FAIL fips_lat_l4 got %0d exp 4", l4);
      end
      vectors++;
      if (l1 != 16) begin
         miscompares++;
         $display("FAIL fips_lat_l1 got %0d exp 16", l1);
      end
      vectors++;
      if (l16 != 1) begin
         miscompares++;
         $display("FAIL fips_lat_l16 got %0d exp 1", l16);
      end
      vectors++;
      if (st4 !== exp_st || err4 !== 1'b0) begin
         miscompares++;
         $display("FAIL fips_l4 got %h/%b exp %h/0", st4, err4, exp_st);
      end
      vectors++;
      if (st1 !== exp_st || err1 !== 1'b0) begin
         miscompares++;
         $display("FAIL fips_l1 got %h/%b exp %h/0", st1, err1, exp_st);
      end
      vectors++;
      if (st16 !== exp_st || err16 !== 1'b0) begin
         miscompares++;
         $display("FAIL fips_l16 got %h/%b exp %h/0", st16, err16, exp_st);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      vectors++;
      if (rdy4 !== 1'b1 || rdy1 !== 1'b1 || rdy16 !== 1'b1) begin
         miscompares++;
         $display("FAIL fips_release got %b%b%b exp 111",
                  rdy4, rdy1, rdy16);
      end
   endtask

   task automatic test_backpressure();
      logic [B-1:0] s, exp_st;
      int r, w;
      r = $urandom_range(4, 10);
      write_key(r, rand128());
      s = rand128();
      exp_st = model(s, r);
      in_valid = 1'b1;
      in_state = s;
      in_round = 4'(r);
      step();
      in_valid = 1'b0;
      w = 0;
      while (!vld4 && w < 40) begin
         step();
         w++;
      end
      vectors++;
      if (vld4 !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_wait got vld %b exp 1", vld4);
      end
      in_valid = 1'b1;
      in_state = rand128();
      for (int i = 0; i < 10; i++) begin
         step();
         vectors++;
         if (vld4 !== 1'b1 || rdy4 !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_hold_hs got vld %b rdy %b exp 1 0",
                     vld4, rdy4);
         end
         vectors++;
         if (st4 !== exp_st) begin
            miscompares++;
            $display("FAIL bp_hold_state got %h exp %h", st4, exp_st);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      vectors++;
      if (rdy4 !== 1'b1 || vld4 !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_release got rdy %b vld %b exp 1 0", rdy4, vld4);
      end
   endtask

   task automatic test_key_hazard();
      logic [B-1:0] s, exp_st, ost;
      logic [3:0] ornd;
      logic oerr;
      int lat;
      write_key(3, '0);
      s = rand128();
      exp_st = model(s, 3);
      run_block(s, 4'd3, 1'b1, 3, '1, lat, ost, ornd, oerr);
      vectors++;
      if (lat != 4) begin
         miscompares++;
         $display("FAIL hazard_lat got %0d exp 4", lat);
      end
      vectors++;
      if (ost !== exp_st || ornd !== 4'd3 || oerr !== 1'b0) begin
         miscompares++;
         $display("FAIL hazard_old got %h/%0d/%b exp %h/3/0",
                  ost, ornd, oerr, exp_st);
      end
      s = rand128();
      run_block(s, 4'd3, 1'b0, 0, '0, lat, ost, ornd, oerr);
      vectors++;
      if (ost !== model(s, 3) || ost !== ~s) begin
         miscompares++;
         $display("FAIL hazard_new got %h exp %h", ost, ~s);
      end
   endtask

   task automatic test_out_of_range();
      logic [B-1:0] s, ost;
      logic [3:0] ornd, r;
      logic oerr;
      int lat;
      for (int k = 0; k < 2; k++) begin
         r = (k == 0) ? 4'd11 : 4'd15;
         s = rand128();
         run_block(s, r, 1'b0, 0, '0, lat, ost, ornd, oerr);
         vectors++;
         if (oerr !== 1'b1 || lat != 4) begin
            miscompares++;
            $display("FAIL oor_err r=%0d got err %b lat %0d exp 1 4",
                     r, oerr, lat);
         end
         vectors++;
         if (ost !== s || ornd !== r) begin
            miscompares++;
            $display("FAIL oor_data got %h/%0d exp %h/%0d",
                     ost, ornd, s, r);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [B-1:0] expq [$];
      logic [3:0]   rq [$];
      int           accq [$];
      int           accs [$];
      logic [B-1:0] e;
      logic [3:0]   er;
      int           ac, sent, got;
      bit           acc;
      for (int a = 0; a < 11; a++) write_key(a, rand128());
      sent = 0;
      got  = 0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_state  = rand128();
      in_round  = 4'($urandom_range(0, 10));
      for (int t = 0; t < 200 && got < 8; t++) begin
         if (vld4) begin
            vectors++;
            if (expq.size() == 0) begin
               miscompares++;
               $display("FAIL b2b_extra got %h exp none", st4);
            end else begin
               e  = expq.pop_front();
               er = rq.pop_front();
               ac = accq.pop_front();
               if (st4 !== e || rnd4 !== er || err4 !== 1'b0) begin
                  miscompares++;
                  $display("FAIL b2b_data got %h/%0d exp %h/%0d",
                           st4, rnd4, e, er);
               end
               vectors++;
               if (cyc - ac != 5) begin
                  miscompares++;
                  $display("FAIL b2b_lat got %0d exp 4", cyc - ac - 1);
               end
            end
            got++;
         end
         acc = in_valid && rdy4;
         if (acc) begin
            expq.push_back(model(in_state, int'(in_round)));
            rq.push_back(in_round);
            accq.push_back(cyc);
            accs.push_back(cyc);
            sent++;
         end
         step();
         if (acc) begin
            if (sent < 8) begin
               in_state = rand128();
               in_round = 4'($urandom_range(0, 10));
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      vectors++;
      if (got != 8 || sent != 8 || expq.size() != 0) begin
         miscompares++;
         $display("FAIL b2b_count got %0d/%0d left %0d exp 8/8 left 0",
                  sent, got, expq.size());
      end
      for (int i = 1; i < accs.size(); i++) begin
         vectors++;
         if (accs[i] - accs[i-1] != 6) begin
            miscompares++;
            $display("FAIL b2b_period got %0d exp 6", accs[i] - accs[i-1]);
         end
      end
   endtask

   task automatic test_reset_mid_busy();
      logic [B-1:0] s, ost;
      logic [3:0] ornd;
      logic oerr;
      int lat;
      step();
      write_key(0, rand128() | 128'h1);
      in_valid = 1'b1;
      in_state = rand128();
      in_round = 4'd0;
      step();
      in_valid = 1'b0;
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 16; i++) kb[i] = '0;
      vectors++;
      if (rdy4 !== 1'b1 || vld4 !== 1'b0) begin
         miscompares++;
         $display("FAIL midrst_hs got rdy %b vld %b exp 1 0", rdy4, vld4);
      end
      vectors++;
      if (st4 !== '0 || rnd4 !== 4'd0 || err4 !== 1'b0) begin
         miscompares++;
         $display("FAIL midrst_out got %h/%0d/%b exp 0/0/0",
                  st4, rnd4, err4);
      end
      s = rand128();
      run_block(s, 4'd0, 1'b0, 0, '0, lat, ost, ornd, oerr);
      vectors++;
      if (ost !== model(s, 0) || ost !== s || lat != 4) begin
         miscompares++;
         $display("FAIL midrst_cleared got %h lat %0d exp %h lat 4",
                  ost, lat, s);
      end
   endtask

   initial begin
      test_reset();
      test_fips();
      test_backpressure();
      test_key_hazard();
      test_out_of_range();
      test_back_to_back();
      test_reset_mid_busy();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
